// File: rtl/rf_pkg.sv
// Shared field layout and payload types for the register-file writeback bundle.
package rf_pkg;

    localparam int unsigned RF_AW = 16;
    localparam int unsigned RF_DW = 16;

    function automatic int unsigned ENTRY_W(input int unsigned aw, input int unsigned dw);
        return 3 + aw + dw;
    endfunction

    // Bit offsets inside one entry {valid, retr, locked, tag, val}
    localparam int unsigned OFF_VAL = 0;

    function automatic int unsigned OFF_TAG(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned OFF_LOCKED(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    function automatic int unsigned OFF_RETR(input int unsigned aw, input int unsigned dw);
        return aw + dw + 1;
    endfunction

    function automatic int unsigned OFF_VALID(input int unsigned aw, input int unsigned dw);
        return aw + dw + 2;
    endfunction

    typedef struct packed {
        logic             valid;
        logic             retr;
        logic             locked;
        logic [RF_AW-1:0] tag;
        logic [RF_DW-1:0] val;
    } rf_entry_t;

    typedef struct packed {
        logic [RF_AW-1:0] ptr;
        logic [RF_DW-1:0] val;
    } wb_payload_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Power-of-two FIFO with synchronous push/pop exposing head, occupancy and full.
module rf_wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is not reset; occupancy gates every read of it
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Buffered writeback and fill application for the per-core register-file bundle.
// Define RF_WB_STATS_EN to add the stat_applied / stat_orphan pop counters.
module rf_wb_queue
    import rf_pkg::*;
#(
    parameter int unsigned NCORES = 4,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NCORES*ENTRY_W(AW, DW)-1:0]  rf_in,
    output logic [NCORES*ENTRY_W(AW, DW)-1:0]  rf_out,
    input  logic                               wb_valid,
    output logic                               wb_ready,
    input  logic [AW-1:0]                      wb_ptr,
    input  logic [DW-1:0]                      wb_val,
    input  logic                               fill_valid,
    input  logic [AW-1:0]                      fill_addr,
    input  logic [DW-1:0]                      fill_data,
    output logic [$clog2(DEPTH):0]             wb_pending
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]                        stat_applied,
    output logic [31:0]                        stat_orphan
`endif
);

    localparam int unsigned EW      = ENTRY_W(AW, DW);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned B_TAG   = OFF_TAG(DW);
    localparam int unsigned B_LOCK  = OFF_LOCKED(AW, DW);
    localparam int unsigned B_RETR  = OFF_RETR(AW, DW);
    localparam int unsigned B_VALID = OFF_VALID(AW, DW);

    logic              f_v;
    logic [AW-1:0]     f_a;
    logic [DW-1:0]     f_d;
    logic [AW+DW-1:0]  head;
    logic [AW-1:0]     head_ptr;
    logic [DW-1:0]     head_val;
    logic [CW-1:0]     count;
    logic              full;
    logic              head_v;
    logic              stall;
    logic              pop;
    logic [NCORES-1:0] wb_hit;

    // Fill port is registered unconditionally; it never backpressures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_v <= 1'b0;
            f_a <= '0;
            f_d <= '0;
        end else begin
            f_v <= fill_valid;
            f_a <= fill_addr;
            f_d <= fill_data;
        end
    end

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wb_valid),
        .pop   (pop),
        .din   ({wb_ptr, wb_val}),
        .head  (head),
        .count (count),
        .full  (full)
    );

    assign head_ptr   = head[DW +: AW];
    assign head_val   = head[DW-1:0];
    assign head_v     = (count != '0);
    assign stall      = f_v && head_v && (f_a == head_ptr);
    assign pop        = head_v && !stall;
    assign wb_ready   = !full;
    assign wb_pending = count;

    // Per-entry update: a fill has priority; a head writeback hits every valid matching tag
    for (genvar i = 0; i < NCORES; i++) begin : g_ent
        logic [EW-1:0] e_in;
        logic [EW-1:0] e_out;
        logic          fill_hit;

        assign e_in      = rf_in[i*EW +: EW];
        assign fill_hit  = f_v && e_in[B_RETR] && (e_in[B_TAG +: AW] == f_a);
        assign wb_hit[i] = head_v && e_in[B_VALID] && (e_in[B_TAG +: AW] == head_ptr);

        always_comb begin
            e_out = e_in;
            if (fill_hit) begin
                e_out[B_RETR]        = 1'b0;
                e_out[B_VALID]       = 1'b1;
                e_out[OFF_VAL +: DW] = f_d;
            end else if (wb_hit[i] && !stall) begin
                e_out[B_LOCK]        = 1'b0;
                e_out[OFF_VAL +: DW] = head_val;
            end
        end

        assign rf_out[i*EW +: EW] = e_out;
    end

`ifdef RF_WB_STATS_EN
    logic any_hit;

    assign any_hit = |wb_hit;

    // Saturating pop classification counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_applied <= '0;
            stat_orphan  <= '0;
        end else if (pop) begin
            if (any_hit) begin
                if (stat_applied != '1) begin
                    stat_applied <= stat_applied + 32'(1);
                end
            end else begin
                if (stat_orphan != '1) begin
                    stat_orphan <= stat_orphan + 32'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed vectors, corner sequences, random vs queue model.
module tb_rf_wb_queue;
    import rf_pkg::*;

    localparam int unsigned NC    = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EW    = ENTRY_W(AW, DW);
    localparam int unsigned BW    = NC * EW;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] rf_in = '0;
    logic [BW-1:0] rf_out;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_ptr = '0;
    logic [DW-1:0] wb_val = '0;
    logic          fill_valid = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic [DW-1:0] fill_data = '0;
    logic [CW-1:0] wb_pending;
`ifdef RF_WB_STATS_EN
    logic [31:0]   stat_applied;
    logic [31:0]   stat_orphan;
`endif

    rf_wb_queue #(.NCORES(NC), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rf_in      (rf_in),
        .rf_out     (rf_out),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_ptr     (wb_ptr),
        .wb_val     (wb_val),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .wb_pending (wb_pending)
`ifdef RF_WB_STATS_EN
        ,
        .stat_applied (stat_applied),
        .stat_orphan  (stat_orphan)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit fb     = 1'b0;

    // Reference model: pending writebacks as a queue, fill as three plain variables
    wb_payload_t mq[$];
    bit          m_fv;
    logic [15:0] m_fa;
    logic [15:0] m_fd;
    logic [31:0] m_applied;
    logic [31:0] m_orphan;

    function automatic void chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic rf_entry_t mk(input bit v, input bit r, input bit l,
                                     input logic [15:0] t, input logic [15:0] d);
        rf_entry_t e;
        e.valid  = v;
        e.retr   = r;
        e.locked = l;
        e.tag    = t;
        e.val    = d;
        return e;
    endfunction

    task automatic set_ent(input int unsigned i, input rf_entry_t e);
        rf_in[i*EW +: EW] = e;
    endtask

    function automatic rf_entry_t ent_out(input int unsigned i);
        return rf_entry_t'(rf_out[i*EW +: EW]);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_fv      = 1'b0;
        m_fa      = '0;
        m_fd      = '0;
        m_applied = '0;
        m_orphan  = '0;
    endfunction

    function automatic void model_comb(input logic [BW-1:0] rin, output logic [BW-1:0] rout,
                                       output bit pop, output bit hit);
        bit          hv;
        bit          stall;
        wb_payload_t h;
        hv    = (mq.size() != 0);
        h     = hv ? mq[0] : '0;
        stall = m_fv && hv && (m_fa == h.ptr);
        pop   = hv && !stall;
        hit   = 1'b0;
        rout  = rin;
        for (int unsigned i = 0; i < NC; i++) begin
            rf_entry_t e;
            e = rf_entry_t'(rin[i*EW +: EW]);
            if (m_fv && e.retr && e.tag == m_fa) begin
                e.retr  = 1'b0;
                e.valid = 1'b1;
                e.val   = m_fd;
            end else if (pop && e.valid && e.tag == h.ptr) begin
                e.locked = 1'b0;
                e.val    = h.val;
                hit      = 1'b1;
            end
            rout[i*EW +: EW] = e;
        end
    endfunction

    // Compare against the model, cross one edge, advance the model, optionally feed rf_out back
    task automatic step();
        logic [BW-1:0] exp_out;
        logic [BW-1:0] nxt;
        bit            pop;
        bit            hit;
        int            pre;
        wb_payload_t   p;
        model_comb(rf_in, exp_out, pop, hit);
        chk("model rf_out", rf_out, exp_out);
        chk("model wb_ready", BW'(wb_ready), BW'(mq.size() != DEPTH));
        chk("model wb_pending", BW'(wb_pending), BW'(mq.size()));
`ifdef RF_WB_STATS_EN
        chk("model stat_applied", BW'(stat_applied), BW'(m_applied));
        chk("model stat_orphan", BW'(stat_orphan), BW'(m_orphan));
`endif
        nxt = rf_out;
        @(posedge clk);
        pre = mq.size();
        if (pop) begin
            void'(mq.pop_front());
            if (hit) m_applied++;
            else     m_orphan++;
        end
        if (wb_valid && pre != DEPTH) begin
            p.ptr = wb_ptr;
            p.val = wb_val;
            mq.push_back(p);
        end
        m_fv = fill_valid;
        m_fa = fill_addr;
        m_fd = fill_data;
        #1;
        if (fb) rf_in = nxt;
    endtask

    task automatic tick();
        #2;
        step();
    endtask

    // Async reset asserted mid-cycle, checked immediately, released after the next edge
    task automatic do_reset();
        wb_valid   = 1'b0;
        fill_valid = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        chk("reset wb_pending", BW'(wb_pending), BW'(0));
        chk("reset wb_ready", BW'(wb_ready), BW'(1));
        chk("reset rf_out==rf_in", rf_out, rf_in);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          is_wb;
        logic [15:0] addr;
        logic [15:0] data;
        rf_entry_t   e_in;
        rf_entry_t   e_exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [BW-1:0] snap;
        model_reset();

        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, mk(1, 0, 1, 16'h0010, 16'h0000), mk(1, 0, 0, 16'h0010, 16'hBEEF)};
        vecs[1] = '{1'b0, 16'h0020, 16'h1234, mk(0, 1, 0, 16'h0020, 16'h0000), mk(1, 0, 0, 16'h0020, 16'h1234)};
        vecs[2] = '{1'b1, 16'h0011, 16'hAAAA, mk(0, 0, 1, 16'h0011, 16'h5555), mk(0, 0, 1, 16'h0011, 16'h5555)};
        vecs[3] = '{1'b0, 16'h0021, 16'h7777, mk(1, 0, 1, 16'h0021, 16'h0001), mk(1, 0, 1, 16'h0021, 16'h0001)};
        vecs[4] = '{1'b0, 16'h0022, 16'h00FF, mk(1, 1, 1, 16'h0022, 16'h0000), mk(1, 0, 1, 16'h0022, 16'h00FF)};
        vecs[5] = '{1'b1, 16'h0012, 16'h0F0F, mk(1, 1, 0, 16'h0012, 16'h0003), mk(1, 1, 0, 16'h0012, 16'h0F0F)};

        // Power-on reset state
        for (int unsigned k = 0; k < NC; k++) set_ent(k, mk(1, 1, 1, 16'h0300 + 16'(k), 16'h0000));
        #3;
        chk("por wb_pending", BW'(wb_pending), BW'(0));
        chk("por wb_ready", BW'(wb_ready), BW'(1));
        chk("por rf_out==rf_in", rf_out, rf_in);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-transaction vectors on entry 2 with decoy neighbours
        fb = 1'b0;
        for (int v = 0; v < 6; v++) begin
            for (int unsigned k = 0; k < NC; k++) set_ent(k, mk(1, 1, 1, 16'h0300 + 16'(k), 16'h0000));
            set_ent(2, vecs[v].e_in);
            if (vecs[v].is_wb) begin
                wb_valid = 1'b1; wb_ptr = vecs[v].addr; wb_val = vecs[v].data;
            end else begin
                fill_valid = 1'b1; fill_addr = vecs[v].addr; fill_data = vecs[v].data;
            end
            tick();
            wb_valid   = 1'b0;
            fill_valid = 1'b0;
            #2;
            chk($sformatf("vec%0d entry2", v), BW'(ent_out(2)), BW'(vecs[v].e_exp));
            for (int unsigned k = 0; k < NC; k++)
                if (k != 2) chk($sformatf("vec%0d entry%0d untouched", v, k), BW'(ent_out(k)),
                                BW'(mk(1, 1, 1, 16'h0300 + 16'(k), 16'h0000)));
            step();
            tick();
        end

        // Backpressure: a fill on the head tag stalls the FIFO while 6 pushes are offered
        fb = 1'b1;
        for (int unsigned k = 0; k < NC; k++) set_ent(k, mk(1, 0, 1, 16'h0050 + 16'(k), 16'h0000));
        fill_valid = 1'b1; fill_addr = 16'h0050; fill_data = 16'hFFFF;
        for (int c = 0; c < 6; c++) begin
            wb_valid = 1'b1;
            wb_ptr   = 16'h0050 + 16'(c);
            wb_val   = 16'hA000 + 16'(c);
            if (c == 5) fill_valid = 1'b0;
            #2;
            if (c >= 4) begin
                chk($sformatf("bp c%0d wb_ready", c), BW'(wb_ready), BW'(0));
                chk($sformatf("bp c%0d wb_pending", c), BW'(wb_pending), BW'(4));
            end
            step();
        end
        wb_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("drain%0d wb_pending", c), BW'(wb_pending), BW'(4 - c));
            chk($sformatf("drain%0d entry%0d", c, c), BW'(ent_out(c)),
                BW'(mk(1, 0, 0, 16'h0050 + 16'(c), 16'hA000 + 16'(c))));
            if (c < 3) chk($sformatf("drain%0d entry%0d still locked", c, c + 1), BW'(ent_out(c + 1).locked), BW'(1));
            step();
        end
        #2;
        chk("drain done wb_pending", BW'(wb_pending), BW'(0));
        step();

        // Fill and head writeback on the same tag in the same cycle
        for (int unsigned k = 0; k < NC; k++) set_ent(k, mk(1, 0, 0, 16'h0200 + 16'(k), 16'h0000));
        set_ent(0, mk(0, 1, 1, 16'h0030, 16'h0000));
        wb_valid = 1'b1; wb_ptr = 16'h0030; wb_val = 16'hC0DE;
        fill_valid = 1'b1; fill_addr = 16'h0030; fill_data = 16'h1111;
        tick();
        wb_valid = 1'b0; fill_valid = 1'b0;
        #2;
        chk("stall fill applied", BW'(ent_out(0)), BW'(mk(1, 0, 1, 16'h0030, 16'h1111)));
        chk("stall pending held", BW'(wb_pending), BW'(1));
        step();
        #2;
        chk("stall head applied", BW'(ent_out(0)), BW'(mk(1, 0, 0, 16'h0030, 16'hC0DE)));
        chk("stall pending late", BW'(wb_pending), BW'(1));
        step();
        #2;
        chk("stall popped", BW'(wb_pending), BW'(0));
        step();

        // Multi-match writeback, then an orphan writeback
        do_reset();
        set_ent(0, mk(1, 0, 1, 16'h0041, 16'h0000));
        set_ent(1, mk(1, 0, 1, 16'h0040, 16'h0000));
        set_ent(2, mk(1, 0, 1, 16'h0041, 16'h0000));
        set_ent(3, mk(1, 0, 1, 16'h0040, 16'h0000));
        wb_valid = 1'b1; wb_ptr = 16'h0040; wb_val = 16'h4444;
        tick();
        wb_valid = 1'b0;
        #2;
        chk("multi entry1", BW'(ent_out(1)), BW'(mk(1, 0, 0, 16'h0040, 16'h4444)));
        chk("multi entry3", BW'(ent_out(3)), BW'(mk(1, 0, 0, 16'h0040, 16'h4444)));
        chk("multi entry0", BW'(ent_out(0)), BW'(mk(1, 0, 1, 16'h0041, 16'h0000)));
        step();
        wb_valid = 1'b1; wb_ptr = 16'h0099; wb_val = 16'h9999;
        tick();
        wb_valid = 1'b0;
        #2;
        chk("orphan rf_out unchanged", rf_out, rf_in);
        step();
        #2;
        chk("orphan popped", BW'(wb_pending), BW'(0));
`ifdef RF_WB_STATS_EN
        chk("stat_applied after multi", BW'(stat_applied), BW'(1));
        chk("stat_orphan after 0x99", BW'(stat_orphan), BW'(1));
`endif
        step();

        // Reset with three writebacks queued behind a stalled head
        for (int unsigned k = 0; k < NC; k++) set_ent(k, mk(1, 0, 1, 16'h0060 + 16'(k), 16'h0000));
        fill_valid = 1'b1; fill_addr = 16'h0060; fill_data = 16'h0BAD;
        for (int c = 0; c < 3; c++) begin
            wb_valid = 1'b1; wb_ptr = 16'h0060 + 16'(c); wb_val = 16'hD000 + 16'(c);
            tick();
        end
        wb_valid = 1'b0;
        #2;
        chk("pre-reset wb_pending", BW'(wb_pending), BW'(3));
        do_reset();
        snap = rf_in;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("post-reset c%0d no stale wb", c), rf_out, snap);
            step();
        end

        // Randomised traffic with feedback and occasional entry perturbation
        do_reset();
        for (int unsigned k = 0; k < NC; k++)
            set_ent(k, mk(1'($urandom), 1'($urandom), 1'($urandom), 16'h0010 + 16'($urandom_range(0, 3)), 16'($urandom)));
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)
                set_ent($urandom_range(0, NC - 1),
                        mk(1'($urandom), 1'($urandom), 1'($urandom), 16'h0010 + 16'($urandom_range(0, 3)), 16'($urandom)));
            wb_valid   = ($urandom_range(0, 2) != 0);
            wb_ptr     = 16'h0010 + 16'($urandom_range(0, 4));
            wb_val     = 16'($urandom);
            fill_valid = ($urandom_range(0, 2) == 0);
            fill_addr  = 16'h0010 + 16'($urandom_range(0, 4));
            fill_data  = 16'($urandom);
            tick();
        end
        wb_valid   = 1'b0;
        fill_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
